eth_port_status: RTL and testbench

- Parametrised successor of the single-port PHY reset counter and SFP link LED logic in the network-interface top level.
- Sequences hardware reset for NUM_PORTS Ethernet PHYs. Initial release is staggered; software can re-reset any single port.
- Synchronises per-port link and remote-fault status into the clk domain.
- Drives link and activity LEDs per port, including the activity indicator the current design lacks.

---
 rtl/eth_port_status.sv | 222 ++++++++++++++++++++++
 tb/tb_eth_port_status.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_port_status.sv
// rtl/eth_port_status.sv - PHY reset sequencer, link/fault synchroniser and link/activity LED driver
// Staggered initial PHY release, one-at-a-time software re-reset, and per-port LED stretchers.
module eth_port_status #(
    parameter int NUM_PORTS      = 4,
    parameter int RST_CYCLES     = 262144,
    parameter int STAGGER_CYCLES = 1024,
    parameter int BLINK_CYCLES   = 6250000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] link_up,
    input  logic [NUM_PORTS-1:0] remote_fault,
    input  logic [NUM_PORTS-1:0] rx_activity,
    input  logic [NUM_PORTS-1:0] tx_activity,
    input  logic [NUM_PORTS-1:0] phy_rst_req,
    output logic [NUM_PORTS-1:0] phy_rst_n,
    output logic                 phys_ready,
    output logic [NUM_PORTS-1:0] led_link,
    output logic [NUM_PORTS-1:0] led_act
);

    localparam int SEQ_MAX = (RST_CYCLES > STAGGER_CYCLES) ? RST_CYCLES : STAGGER_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int ACT_W   = $clog2(2 * BLINK_CYCLES);

    localparam logic [SEQ_W-1:0]   RST_LAST   = SEQ_W'(RST_CYCLES - 1);
    localparam logic [SEQ_W-1:0]   STG_LAST   = SEQ_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_PORTS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [ACT_W-1:0]   ACT_LOAD   = ACT_W'(2 * BLINK_CYCLES - 1);
    localparam logic [ACT_W-1:0]   ACT_ON     = ACT_W'(BLINK_CYCLES);

    localparam logic [2:0] ST_HOLD     = 3'd0;
    localparam logic [2:0] ST_RELEASE  = 3'd1;
    localparam logic [2:0] ST_READY    = 3'd2;
    localparam logic [2:0] ST_REHOLD   = 3'd3;
    localparam logic [2:0] ST_RESETTLE = 3'd4;

    logic [2:0]           state;
    logic [SEQ_W-1:0]     seq_cnt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     low_idx;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] req_set;
    logic [NUM_PORTS-1:0] sel_clr;
    logic [NUM_PORTS-1:0] pend_nx;
    logic                 rst_done;
    logic                 stg_done;
    logic                 sel_go;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = IDX_W'(i);
        end
        rst_done = (seq_cnt == RST_LAST);
        stg_done = (seq_cnt == STG_LAST);
        sel_go   = (pending != '0) &&
                   ((state == ST_READY) || ((state == ST_RESETTLE) && stg_done));
        sel_clr  = sel_go ? (NUM_PORTS'(1) << low_idx) : '0;
        // A port still held in reset cannot queue another reset of itself
        req_set  = phy_rst_req & phy_rst_n;
        pend_nx  = (pending | req_set) & ~sel_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HOLD;
            seq_cnt    <= '0;
            idx        <= '0;
            sel        <= '0;
            pending    <= '0;
            phy_rst_n  <= '0;
            phys_ready <= 1'b0;
        end else begin
            pending <= pend_nx;
            if (sel_go) begin
                sel                <= low_idx;
                phy_rst_n[low_idx] <= 1'b0;
                phys_ready         <= 1'b0;
                seq_cnt            <= '0;
                state              <= ST_REHOLD;
            end else begin
                case (state)
                    ST_HOLD: begin
                        if (rst_done) begin
                            seq_cnt      <= '0;
                            idx          <= '0;
                            phy_rst_n[0] <= 1'b1;
                            state        <= ST_RELEASE;
                        end else begin
                            seq_cnt <= seq_cnt + SEQ_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (stg_done) begin
                            seq_cnt <= '0;
                            if (idx == IDX_LAST) begin
                                phys_ready <= (pend_nx == '0);
                                state      <= ST_READY;
                            end else begin
                                idx                          <= idx + IDX_W'(1);
                                phy_rst_n[idx + IDX_W'(1)]   <= 1'b1;
                            end
                        end else begin
                            seq_cnt <= seq_cnt + SEQ_W'(1);
                        end
                    end
                    ST_READY: begin
                        seq_cnt <= '0;
                    end
                    ST_REHOLD: begin
                        if (rst_done) begin
                            seq_cnt        <= '0;
                            phy_rst_n[sel] <= 1'b1;
                            state          <= ST_RESETTLE;
                        end else begin
                            seq_cnt <= seq_cnt + SEQ_W'(1);
                        end
                    end
                    ST_RESETTLE: begin
                        if (stg_done) begin
                            seq_cnt    <= '0;
                            phys_ready <= (pend_nx == '0);
                            state      <= ST_READY;
                        end else begin
                            seq_cnt <= seq_cnt + SEQ_W'(1);
                        end
                    end
                    default: begin
                        seq_cnt <= '0;
                        state   <= ST_HOLD;
                    end
                endcase
            end
        end
    end

    logic [NUM_PORTS-1:0] link_pipe  [SYNC_STAGES];
    logic [NUM_PORTS-1:0] fault_pipe [SYNC_STAGES];
    logic [NUM_PORTS-1:0] sync_link;
    logic [NUM_PORTS-1:0] sync_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                link_pipe[s]  <= '0;
                fault_pipe[s] <= '0;
            end
        end else begin
            link_pipe[0]  <= link_up;
            fault_pipe[0] <= remote_fault;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                link_pipe[s]  <= link_pipe[s-1];
                fault_pipe[s] <= fault_pipe[s-1];
            end
        end
    end

    assign sync_link  = link_pipe[SYNC_STAGES-1];
    assign sync_fault = fault_pipe[SYNC_STAGES-1];

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [ACT_W-1:0] act_cnt;
        logic             act_pend;
        logic             port_on;
        logic             act;
        logic             link_q;
        logic             act_q;

        assign port_on = sync_link[i] & phy_rst_n[i];
        assign act     = (rx_activity[i] | tx_activity[i]) & port_on;

        // A second event during a flash queues exactly one more full on/off flash
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                act_cnt  <= '0;
                act_pend <= 1'b0;
                link_q   <= 1'b0;
                act_q    <= 1'b0;
            end else begin
                link_q <= port_on & (~sync_fault[i] | blink_phase);
                act_q  <= port_on & (act_cnt >= ACT_ON);
                if (!port_on) begin
                    act_cnt  <= '0;
                    act_pend <= 1'b0;
                end else if (act_cnt == '0) begin
                    if (act || act_pend) begin
                        act_cnt  <= ACT_LOAD;
                        act_pend <= 1'b0;
                    end
                end else begin
                    act_cnt <= act_cnt - ACT_W'(1);
                    if (act) act_pend <= 1'b1;
                end
            end
        end

        assign led_link[i] = link_q;
        assign led_act[i]  = act_q;
    end

endmodule

// File: tb/tb_eth_port_status.sv
// tb/tb_eth_port_status.sv - directed bench for eth_port_status
module tb_eth_port_status;

    logic       clk;
    logic       rst;
    logic [1:0] link_up;
    logic [1:0] remote_fault;
    logic [1:0] rx_activity;
    logic [1:0] tx_activity;
    logic [1:0] phy_rst_req;
    logic [1:0] phy_rst_n;
    logic       phys_ready;
    logic [1:0] led_link;
    logic [1:0] led_act;

    int checks;
    int errors;
    int cyc;

    eth_port_status #(
        .NUM_PORTS      (2),
        .RST_CYCLES     (16),
        .STAGGER_CYCLES (4),
        .BLINK_CYCLES   (8),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .link_up      (link_up),
        .remote_fault (remote_fault),
        .rx_activity  (rx_activity),
        .tx_activity  (tx_activity),
        .phy_rst_req  (phy_rst_req),
        .phy_rst_n    (phy_rst_n),
        .phys_ready   (phys_ready),
        .led_link     (led_link),
        .led_act      (led_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic test_reset;
        rst = 1'b1;
        phy_rst_req = 2'b00;
        rx_activity = 2'b00;
        tx_activity = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({phy_rst_n, phys_ready, led_link, led_act} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: got n=%b rdy=%b ll=%b la=%b, want all 0",
                     phy_rst_n, phys_ready, led_link, led_act);
        end
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            phy_rst_req = (k == 5 || k == 18) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++;
            if (phy_rst_n !== (k >= 20 ? 2'b11 : (k >= 16 ? 2'b01 : 2'b00))) begin
                errors++;
                $display("FAIL seq_phy_rst_n edge=%0d: got %b", k, phy_rst_n);
            end
            checks++;
            if (phys_ready !== (k >= 24)) begin
                errors++;
                $display("FAIL seq_ready edge=%0d: got %b want %b", k, phys_ready, k >= 24);
            end
            checks++;
            if ({led_link, led_act} !== 4'b0) begin
                errors++;
                $display("FAIL seq_leds edge=%0d: got ll=%b la=%b want 0", k, led_link, led_act);
            end
        end
        phy_rst_req = 2'b00;
    endtask

    task automatic test_rereset_single;
        phy_rst_req = 2'b10;
        @(negedge clk);
        phy_rst_req = 2'b00;
        checks++;
        if ({phy_rst_n, phys_ready} !== 3'b111) begin
            errors++;
            $display("FAIL single_req_edge: got n=%b rdy=%b want 11/1", phy_rst_n, phys_ready);
        end
        @(negedge clk);
        checks++;
        if ({phy_rst_n, phys_ready} !== 3'b010) begin
            errors++;
            $display("FAIL single_enter: got n=%b rdy=%b want 01/0", phy_rst_n, phys_ready);
        end
        for (int j = 1; j <= 20; j++) begin
            phy_rst_req = (j == 5) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++;
            if ({phy_rst_n, phys_ready} !== {(j >= 16), 1'b1, (j >= 20)}) begin
                errors++;
                $display("FAIL single_rehold j=%0d: got n=%b rdy=%b", j, phy_rst_n, phys_ready);
            end
        end
        phy_rst_req = 2'b00;
    endtask

    task automatic test_rereset_double;
        phy_rst_req = 2'b11;
        @(negedge clk);
        phy_rst_req = 2'b00;
        @(negedge clk);
        checks++;
        if ({phy_rst_n, phys_ready} !== 3'b100) begin
            errors++;
            $display("FAIL double_enter: got n=%b rdy=%b want 10/0", phy_rst_n, phys_ready);
        end
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            checks++;
            if ({phy_rst_n, phys_ready} !== {!(j >= 20 && j < 36), (j >= 16), (j >= 40)}) begin
                errors++;
                $display("FAIL double_seq j=%0d: got n=%b rdy=%b", j, phy_rst_n, phys_ready);
            end
        end
    endtask

    task automatic test_link_led;
        link_up = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (led_link !== ((k == 3) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL link_latency k=%0d: got %b", k, led_link);
            end
        end
        remote_fault = 2'b01;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checks++;
            if (led_link !== {1'b0, 1'(((cyc - 1) / 8) % 2)}) begin
                errors++;
                $display("FAIL fault_blink cyc=%0d: got %b", cyc, led_link);
            end
        end
        remote_fault = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (led_link !== 2'b01) begin
            errors++;
            $display("FAIL fault_clear: got %b want 01", led_link);
        end
    endtask

    task automatic test_activity;
        for (int k = 0; k <= 32; k++) begin
            rx_activity = (k == 0) ? 2'b11 : ((k == 3) ? 2'b01 : 2'b00);
            tx_activity = (k == 3) ? 2'b11 : 2'b00;
            @(negedge clk);
            checks++;
            if (led_act !== {1'b0, ((k >= 1 && k <= 8) || (k >= 17 && k <= 24))}) begin
                errors++;
                $display("FAIL act_flash k=%0d: got %b", k, led_act);
            end
        end
        rx_activity = 2'b00;
        tx_activity = 2'b00;
    endtask

    task automatic test_link_drop;
        for (int k = 0; k <= 6; k++) begin
            rx_activity = (k == 0) ? 2'b01 : 2'b00;
            if (k == 4) link_up = 2'b00;
            @(negedge clk);
            checks++;
            if (led_act !== {1'b0, (k >= 1 && k <= 5)}) begin
                errors++;
                $display("FAIL link_drop_act k=%0d: got %b", k, led_act);
            end
        end
        checks++;
        if (led_link !== 2'b00) begin
            errors++;
            $display("FAIL link_drop_led: got %b want 00", led_link);
        end
        rx_activity = 2'b00;
    endtask

    task automatic test_reset_midrelease;
        repeat (18) @(negedge clk);
        checks++;
        if ({phy_rst_n, phys_ready} !== 3'b010) begin
            errors++;
            $display("FAIL midrel_pre: got n=%b rdy=%b want 01/0", phy_rst_n, phys_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({phy_rst_n, phys_ready, led_link, led_act} !== 7'b0) begin
            errors++;
            $display("FAIL midrel_async: got n=%b rdy=%b ll=%b la=%b, want all 0",
                     phy_rst_n, phys_ready, led_link, led_act);
        end
        test_reset();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        link_up      = 2'b00;
        remote_fault = 2'b00;
        rx_activity  = 2'b00;
        tx_activity  = 2'b00;
        phy_rst_req  = 2'b00;
        test_reset();
        test_rereset_single();
        test_rereset_double();
        test_link_led();
        test_activity();
        test_link_drop();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        test_reset_midrelease();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
